// File: rtl/frost32_irq_ctrl.sv
// Frost32 interrupt controller: edge-detects NUM_SRC async request lines, masks and
// prioritises the pending bits, and holds one interrupt/vector pair until the CPU acks it.
module frost32_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned VEC_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               int_ack,
    output logic               interrupt,
    output logic [VEC_W-1:0]   int_vector
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] src_rise, pending, mask, cand;
    logic [NUM_SRC-1:0] clr, sw_set, ack_clr, wdata_src;
    logic [1:0]         warm;
    logic               global_en;
    logic               wr_mask, wr_clear, wr_ctrl, wr_set;
    logic               ack_now, latch_vec, enc_hit;
    logic [VEC_W-1:0]   enc_vec;
    logic               unused_wdata;

    assign wdata_src    = cfg_wdata[NUM_SRC-1:0];
    assign unused_wdata = ^cfg_wdata;

    // A line already high when reset releases is taken as a level, not an edge:
    // rises only count once prev holds a post-reset sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            warm  <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            prev  <= sync2;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
        end
    end

    assign src_rise = (warm == 2'd3) ? (sync2 & ~prev) : '0;

    assign wr_mask  = cfg_we && (cfg_addr == 2'd0);
    assign wr_clear = cfg_we && (cfg_addr == 2'd1);
    assign wr_ctrl  = cfg_we && (cfg_addr == 2'd2);
    assign wr_set   = cfg_we && (cfg_addr == 2'd3);

    assign ack_now = (state == ASSERT) && int_ack;
    assign ack_clr = ack_now ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << int_vector) : '0;
    assign clr     = ack_clr | (wr_clear ? wdata_src : '0);
    assign sw_set  = wr_set ? wdata_src : '0;
    assign cand    = pending & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            mask      <= '0;
            global_en <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | src_rise | sw_set;
            if (wr_mask)
                mask <= wdata_src;
            if (wr_ctrl)
                global_en <= cfg_wdata[0];
        end
    end

    always_comb begin
        enc_vec = '0;
        enc_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && !enc_hit) begin
                enc_hit = 1'b1;
                enc_vec = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        latch_vec  = 1'b0;
        case (state)
            IDLE: begin
                if (global_en && enc_hit) begin
                    state_next = ASSERT;
                    latch_vec  = 1'b1;
                end
            end
            ASSERT: begin
                if (int_ack)
                    state_next = HOLDOFF;
            end
            HOLDOFF: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            int_vector <= '0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == ASSERT);
            if (latch_vec)
                int_vector <= enc_vec;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[NUM_SRC-1:0] = mask;
            2'd1: cfg_rdata[NUM_SRC-1:0] = pending;
            2'd2: begin
                cfg_rdata[0]            = global_en;
                cfg_rdata[9:8]          = state;
                cfg_rdata[10 +: VEC_W]  = int_vector;
            end
            default: cfg_rdata[NUM_SRC-1:0] = cand;
        endcase
    end

endmodule

// File: tb/tb_frost32_irq_ctrl.sv
// Scoreboard bench for frost32_irq_ctrl: a per-edge reference model pushes expected
// interrupt/vector pairs; a negedge monitor pops and compares them.
module tb_frost32_irq_ctrl;

    localparam int N  = 8;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  irq_src = '1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          int_ack = 1'b0;
    logic          interrupt;
    logic [VW-1:0] int_vector;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];

    // reference model state
    logic [N-1:0] m_pend, m_mask, p1, p2, p3, src_r;
    logic         m_gen;
    int           m_phase;   // 0 idle, 1 requesting, 2 forced-low cycle
    int           m_vec;
    int           m_since;

    frost32_irq_ctrl #(.NUM_SRC(N), .VEC_W(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .int_ack    (int_ack),
        .interrupt  (interrupt),
        .int_vector (int_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] c);
        logic [N-1:0] x;
        x = c & (~c + 1'b1);
        return $clog2(x);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_pend);
            2'd2:    return (32'(m_phase) << 8) | 32'(m_gen);
            default: return 32'(m_pend & m_mask);
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_gen = 1'b0;
        m_phase = 0; m_vec = 0; m_since = 0;
        p1 = '0; p2 = '0; p3 = '0;
    endtask

    task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] wd,
                              input logic ack, input logic [N-1:0] src);
        logic [N-1:0] rise, cand, clr, set;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // a rise seen at this edge was applied two edges earlier; a level present
        // at the first sample after reset is never an edge
        rise = (m_since >= 3) ? (p2 & ~p3) : '0;
        cand = m_pend & m_mask;
        clr  = (we && a == 2'd1) ? wd[N-1:0] : '0;
        if (m_phase == 1 && ack)
            clr = clr | N'(32'd1 << m_vec);
        set  = (we && a == 2'd3) ? wd[N-1:0] : '0;
        case (m_phase)
            0: if (m_gen && cand != 0) begin m_phase = 1; m_vec = lowest(cand); end
            1: if (ack) m_phase = 2;
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise | set;
        if (we && a == 2'd0) m_mask = wd[N-1:0];
        if (we && a == 2'd2) m_gen = wd[0];
        p3 = p2; p2 = p1; p1 = src;
        m_since++;
    endtask

    task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input logic ack, input logic [N-1:0] src);
        cfg_we = we; cfg_addr = a; cfg_wdata = wd; int_ack = ack; irq_src = src;
        #1;
        chk($sformatf("rdata@%0d", a), cfg_rdata & ((a == 2'd2) ? 32'h3FF : 32'hFFFF_FFFF),
            model_read(a));
        @(posedge clk);
        model_step(we, a, wd, ack, src);
        exp_q.push_back((m_phase == 1) ? (32'h100 | 32'(m_vec)) : 32'h0);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 2'($urandom_range(0, 3)), 32'h0, 1'b0, src_r);
    endtask

    task automatic ack_cycle();
        cycle(1'b0, 2'($urandom_range(0, 3)), 32'h0, 1'b1, src_r);
    endtask

    task automatic wait_int();
        for (int i = 0; i < 12; i++) begin
            if (interrupt) return;
            idle();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_int: interrupt never rose within 12 cycles");
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("irq_out", interrupt ? (32'h100 | 32'(int_vector)) : 32'h0, e);
        end
    end

    initial begin
        model_reset();
        src_r = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_interrupt", 32'(interrupt), 32'h0);
        chk("rst_vector", 32'(int_vector), 32'h0);
        cycle(1'b0, 2'd1, 32'h0, 1'b0, src_r);
        cycle(1'b0, 2'd1, 32'h0, 1'b0, src_r);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'd1, 32'h0, 1'b0, src_r);
        chk("no_edge_after_rst", cfg_rdata, 32'h0);

        // latency and single holdoff
        cycle(1'b1, 2'd0, 32'hFF, 1'b0, src_r);
        cycle(1'b1, 2'd2, 32'h1, 1'b0, src_r);
        src_r = '0;
        idle(); idle();
        src_r = 8'h08;
        idle(); idle(); idle();
        chk("lat_pre", 32'(interrupt), 32'h0);
        idle();
        chk("lat_vec", {interrupt, int_vector}, {1'b1, 3'd3});
        ack_cycle();
        chk("ack_low", 32'(interrupt), 32'h0);
        idle();

        // priority
        src_r = '0;
        idle(); idle();
        src_r = 8'h24;
        wait_int();
        chk("prio_first", 32'(int_vector), 32'd2);
        ack_cycle();
        wait_int();
        chk("prio_second", 32'(int_vector), 32'd5);
        ack_cycle();
        for (int i = 0; i < 4; i++) idle();
        chk("prio_done", 32'(interrupt), 32'h0);

        // edge colliding with the ack of the same source
        src_r = '0;
        idle(); idle();
        src_r = 8'h04;
        wait_int();
        src_r = '0;
        idle(); idle();
        src_r = 8'h04;
        idle(); idle();
        ack_cycle();
        chk("coll_low", 32'(interrupt), 32'h0);
        wait_int();
        chk("coll_rereq", 32'(int_vector), 32'd2);
        ack_cycle();

        // masking
        cycle(1'b1, 2'd0, 32'h01, 1'b0, src_r);
        src_r = '0;
        idle(); idle();
        src_r = 8'h10;
        for (int i = 0; i < 5; i++) idle();
        chk("masked_quiet", 32'(interrupt), 32'h0);
        cycle(1'b1, 2'd0, 32'h10, 1'b0, src_r);
        wait_int();
        chk("unmask_vec", 32'(int_vector), 32'd4);
        cycle(1'b1, 2'd3, 32'h01, 1'b0, src_r);
        idle(); idle();
        chk("hold_vec", {interrupt, int_vector}, {1'b1, 3'd4});
        ack_cycle();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic we;
            if ($urandom_range(0, 3) == 0)
                src_r = src_r ^ N'(32'd1 << $urandom_range(0, N - 1));
            we = ($urandom_range(0, 7) == 0);
            cycle(we, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom,
                  ($urandom_range(0, 2) == 0), src_r);
        end

        // async reset while requesting
        cycle(1'b1, 2'd0, 32'hFF, 1'b0, src_r);
        cycle(1'b1, 2'd2, 32'h1, 1'b0, src_r);
        cycle(1'b1, 2'd3, 32'h1, 1'b0, src_r);
        wait_int();
        cfg_addr = 2'd2;
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_rst_int", 32'(interrupt), 32'h0);
        chk("async_rst_state", cfg_rdata & 32'h3FF, 32'h0);
        model_reset();
        cycle(1'b0, 2'd1, 32'h0, 1'b0, src_r);
        cycle(1'b0, 2'd2, 32'h0, 1'b0, src_r);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle();

        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
